instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/if_pkg.sv | 22 ++
 rtl/fetch_skid_buf.sv | 29 ++
 rtl/instr_fetch_unit.sv | 135 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch unit.
package if_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid register holding a fetched {pc, instr} pair that arrived
// while the output stage was full and stalled.
module fetch_skid_buf
  import if_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic         pop,
  input  fetch_entry_t load_entry,
  output logic         valid,
  output fetch_entry_t entry
);

  // Clear beats load, load beats pop (a simultaneous load+pop replaces the entry).
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      valid <= 1'b0;
      entry <= '0;
    end else if (load) begin
      valid <= 1'b1;
      entry <= load_entry;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues one outstanding instruction-memory read at a
// time, buffers one response in a skid entry under stall, and discards stale
// responses after a redirect.
module instr_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = if_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        instr_valid
);

  fetch_state_e state;
  logic [31:0]  fetch_pc;
  logic [31:0]  req_pc;

  logic         skid_valid;
  fetch_entry_t skid_entry;
  logic         skid_load;
  logic         skid_pop;

  logic         accepted;
  logic         rsp;
  logic         consume;
  logic         out_free;
  fetch_entry_t rsp_entry;

  // Requests are held back while both the output and skid slots are occupied,
  // so a returning response always has somewhere to land.
  assign imem_req  = !reset && (state == FETCH_REQ) && !(instr_valid && skid_valid);
  assign imem_addr = fetch_pc;

  assign accepted  = imem_req && imem_gnt;
  assign rsp       = (state == FETCH_WAIT) && imem_rvalid;
  assign consume   = instr_valid && !stall;
  assign out_free  = !instr_valid || consume;
  assign rsp_entry = '{pc: req_pc, instr: imem_rdata};

  // Skid control: refill output from skid first, park responses that cannot enter the output.
  always_comb begin
    skid_load = 1'b0;
    skid_pop  = 1'b0;
    if (!redirect_valid) begin
      if (out_free) begin
        skid_pop  = skid_valid;
        skid_load = skid_valid && rsp;
      end else begin
        skid_load = rsp;
      end
    end
  end

  fetch_skid_buf u_skid (
    .clk        (clk),
    .reset      (reset),
    .clear      (redirect_valid),
    .load       (skid_load),
    .pop        (skid_pop),
    .load_entry (rsp_entry),
    .valid      (skid_valid),
    .entry      (skid_entry)
  );

  // Fetch FSM: request issue, response wait, and stale-response drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH_REQ;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
    end else begin
      case (state)
        FETCH_REQ: begin
          if (redirect_valid) begin
            fetch_pc <= word_align(redirect_pc);
            if (accepted) state <= FETCH_DROP;
          end else if (accepted) begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + 32'd4;
            state    <= FETCH_WAIT;
          end
        end
        FETCH_WAIT: begin
          if (redirect_valid) begin
            fetch_pc <= word_align(redirect_pc);
            // A response arriving in the redirect cycle is itself the stale
            // one; it is discarded here and there is nothing left to drop.
            state    <= imem_rvalid ? FETCH_REQ : FETCH_DROP;
          end else if (imem_rvalid) begin
            state <= FETCH_REQ;
          end
        end
        FETCH_DROP: begin
          if (redirect_valid) fetch_pc <= word_align(redirect_pc);
          if (imem_rvalid) state <= FETCH_REQ;
        end
        default: state <= FETCH_REQ;
      endcase
    end
  end

  // Output register: flush on redirect, hold on stall, else refill from skid or response.
  always_ff @(posedge clk) begin
    if (reset || redirect_valid) begin
      instr_valid <= 1'b0;
      instr_out   <= NOP_INSTR;
      pc_out      <= '0;
    end else if (out_free) begin
      if (skid_valid) begin
        instr_valid <= 1'b1;
        pc_out      <= skid_entry.pc;
        instr_out   <= skid_entry.instr;
      end else if (rsp) begin
        instr_valid <= 1'b1;
        pc_out      <= rsp_entry.pc;
        instr_out   <= rsp_entry.instr;
      end else if (consume) begin
        instr_valid <= 1'b0;
        instr_out   <= NOP_INSTR;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed vector table, hand-written
// corner sequences, and randomized traffic against a stream-level model.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        instr_valid;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .pc_out         (pc_out),
    .instr_out      (instr_out),
    .instr_valid    (instr_valid)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  typedef struct {
    logic        rst;
    logic        st;
    logic        rv;
    logic [31:0] rpc;
    logic        g;
    logic        v;
    logic [31:0] d;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t tbl[14];

  // Instruction memory contents: a distinct word per address.
  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  task automatic check_row(input int idx, input logic [97:0] act, input logic [97:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL vec[%0d] {req,addr,valid,pc,instr}: got %025h expected %025h", idx, act, exp);
  endtask

  // Drive one cycle's inputs at the falling edge; outputs are stable 1 time unit later.
  task automatic cyc(input logic rst, input logic st, input logic rv, input logic [31:0] rpc,
                     input logic g, input logic v, input logic [31:0] d);
    @(negedge clk);
    reset          = rst;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_gnt       = g;
    imem_rvalid    = v;
    imem_rdata     = d;
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, limit 500000");
    $fatal(1);
  end

  // Random-phase state
  logic        r_st, r_rv, r_g, r_v;
  logic [31:0] r_rpc;
  logic        pend;
  logic [31:0] pend_addr;
  int unsigned pend_dly;
  logic [31:0] exp_pc, exp_fetch;
  int unsigned idle, delivered;
  logic        prev_hold;
  logic [31:0] prev_pc, prev_instr;

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

    // Back-to-back fetch after reset, then a redirect to the top of memory.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         NOP};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0,         NOP};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0010_0093, 1'b0, 32'h4,         1'b0, 32'h0,         NOP};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'h4,         1'b1, 32'h0,         32'h0010_0093};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0020_0113, 1'b0, 32'h8,         1'b0, 32'h0,         NOP};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'h8,         1'b1, 32'h4,         32'h0020_0113};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0030_0193, 1'b0, 32'hC,         1'b0, 32'h4,         NOP};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'hC,         1'b1, 32'h8,         32'h0030_0193};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'hC,         1'b0, 32'h8,         NOP};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'h0,         1'b1, 32'hC,         1'b0, 32'h8,         NOP};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,         NOP};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0040_0213, 1'b0, 32'h0,         1'b0, 32'h0,         NOP};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         1'b1, 32'hFFFF_FFFC, 32'h0040_0213};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 32'hFFFF_FFFC, NOP};

    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    foreach (tbl[k]) begin
      cyc(tbl[k].rst, tbl[k].st, tbl[k].rv, tbl[k].rpc, tbl[k].g, tbl[k].v, tbl[k].d);
      check_row(k, {imem_req, imem_addr, instr_valid, pc_out, instr_out},
                {tbl[k].e_req, tbl[k].e_addr, tbl[k].e_valid, tbl[k].e_pc, tbl[k].e_instr});
    end

    // Stall with a response in flight: second response parks in skid, requests stop.
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hAAAA_0001);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check("stall req with free skid", imem_req, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hBBBB_0002);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      check("stall full req", imem_req, 1'b0);
      check("stall hold valid", instr_valid, 1'b1);
      check("stall hold pc", pc_out, 32'h0);
      check("stall hold instr", instr_out, 32'hAAAA_0001);
    end
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("unstall first pc", pc_out, 32'h0);
    check("unstall first instr", instr_out, 32'hAAAA_0001);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("unstall second valid", instr_valid, 1'b1);
    check("unstall second pc", pc_out, 32'h4);
    check("unstall second instr", instr_out, 32'hBBBB_0002);
    check("unstall req resumes", imem_req, 1'b1);
    check("unstall req addr", imem_addr, 32'h8);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("unstall drained", instr_valid, 1'b0);

    // Redirect while waiting: the stale response is dropped.
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    check("drop req low", imem_req, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check("drop no output", instr_valid, 1'b0);
    check("drop next req", imem_req, 1'b1);
    check("drop next addr", imem_addr, 32'h100);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hCCCC_0003);
    check("drop still empty", instr_valid, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("drop first valid", instr_valid, 1'b1);
    check("drop first pc", pc_out, 32'h100);
    check("drop first instr", instr_out, 32'hCCCC_0003);

    // Redirect and stall together with a valid output.
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hAAAA_0001);
    cyc(1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
    check("redir+stall pre valid", instr_valid, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("redir+stall instr", instr_out, NOP);
    check("redir+stall valid", instr_valid, 1'b0);
    check("redir+stall pc", pc_out, 32'h0);
    check("redir+stall req", imem_req, 1'b1);
    check("redir+stall addr", imem_addr, 32'h200);

    // Reset during WAIT abandons the request.
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hAAAA_0001);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check("rst-wait pre valid", instr_valid, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("rst-wait req in reset", imem_req, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("rst-wait valid", instr_valid, 1'b0);
    check("rst-wait instr", instr_out, NOP);
    check("rst-wait req", imem_req, 1'b1);
    check("rst-wait addr", imem_addr, 32'h0);

    // Randomized traffic against a program-order stream model.
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    pend = 1'b0; pend_addr = '0; pend_dly = 0;
    exp_pc = 32'h0; exp_fetch = 32'h0;
    idle = 0; delivered = 0;
    prev_hold = 1'b0; prev_pc = '0; prev_instr = '0;
    for (int i = 0; i < 3000; i++) begin
      r_st  = ($urandom_range(0, 9) < 3);
      r_rv  = ($urandom_range(0, 49) == 0);
      r_rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      r_g   = ($urandom_range(0, 9) < 7);
      r_v   = pend && (pend_dly == 0);
      cyc(1'b0, r_st, r_rv, r_rpc, r_g, r_v, r_v ? memfn(pend_addr) : $urandom);

      if (prev_hold) begin
        check("rand hold valid", instr_valid, 1'b1);
        check("rand hold pc", pc_out, prev_pc);
        check("rand hold instr", instr_out, prev_instr);
      end
      if (instr_valid) begin
        check("rand stream pc", pc_out, exp_pc);
        check("rand stream instr", instr_out, memfn(exp_pc));
      end else begin
        check("rand bubble", instr_out, NOP);
      end
      if (imem_req) check("rand single outstanding", {31'b0, pend}, 32'h0);
      if (imem_req && r_g && !r_rv) begin
        check("rand fetch addr", imem_addr, exp_fetch);
        exp_fetch = exp_fetch + 32'd4;
      end

      if (instr_valid && !r_st && !r_rv) begin
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      if (r_rv) begin
        exp_pc    = r_rpc & 32'hFFFF_FFFC;
        exp_fetch = r_rpc & 32'hFFFF_FFFC;
      end

      if (r_v) pend = 1'b0;
      else if (pend) pend_dly--;
      if (imem_req && r_g) begin
        pend      = 1'b1;
        pend_addr = imem_addr;
        pend_dly  = $urandom_range(0, 3);
      end

      prev_hold  = instr_valid && r_st && !r_rv;
      prev_pc    = pc_out;
      prev_instr = instr_out;

      if (instr_valid) idle = 0;
      else idle++;
      if (idle > 80) begin
        n_checks++;
        $display("FAIL rand progress: %0d idle cycles, limit 80", idle);
        break;
      end
    end
    check("rand delivered enough", {31'b0, delivered > 200}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
